// File: rtl/fp_pkg.sv
// Shared single-precision field constants, class encoding and integer limits.
package fp_pkg;

  localparam int MAN   = 23;
  localparam int EXP   = 8;
  localparam int BIAS  = (1 << (EXP - 1)) - 1;
  localparam int OUT_W = 23;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fcls_e;

endpackage

// File: rtl/float2int_core.sv
// Stateless datapath: S2 shift of the significand and S3 sign/saturate.
// The pipe registers sit in the top; both halves share this module.
module float2int_core import fp_pkg::*; #(
  parameter int MAN   = fp_pkg::MAN,
  parameter int EXP   = fp_pkg::EXP,
  parameter int OUT_W = fp_pkg::OUT_W
) (
  // shift half (fed from S1 registers)
  input  logic                  sig_sign,
  input  logic [MAN:0]          sig,
  input  logic signed [EXP:0]   e,
  input  fcls_e                 cls,
  output logic [OUT_W:0]        mag,
  output logic                  ovf,
  output logic                  nan,
  // finish half (fed from S2 registers)
  input  logic                  fin_sign,
  input  logic [OUT_W:0]        fin_mag,
  input  logic                  fin_ovf,
  input  logic                  fin_nan,
  output logic [OUT_W-1:0]      res,
  output logic                  sat,
  output logic                  res_nan
);

  // Wide enough for the unshifted significand and for the largest in-range left shift.
  localparam int WW = ((MAN > OUT_W) ? MAN : OUT_W) + 1;

  localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_V   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V   = {1'b1, {(OUT_W-1){1'b0}}};

  logic [WW-1:0] wide;
  int            ei;

  // Shift: overflow is decided from e first so the shifter only sees 0 <= e <= OUT_W.
  // Right shifts drop fraction bits, which truncates toward zero. Sign rides alongside.
  always_comb begin
    wide = '0;
    mag  = '0;
    ovf  = 1'b0;
    nan  = 1'b0;
    ei   = int'(e);
    case (cls)
      NAN: nan = 1'b1;
      INF: ovf = 1'b1;
      NORM: begin
        if (ei > OUT_W) begin
          ovf = 1'b1;
        end else if (ei >= 0) begin
          wide = WW'(sig);
          if (ei >= MAN) wide = wide << (ei - MAN);
          else           wide = wide >> (MAN - ei);
          mag = wide[OUT_W:0];
        end
      end
      default: ;
    endcase
  end

  // Finish: negate, clamp to the signed range; -2^(OUT_W-1) itself is exact.
  always_comb begin
    res     = '0;
    sat     = 1'b0;
    res_nan = fin_nan;
    if (fin_nan) begin
      res = '0;
    end else if (fin_ovf) begin
      sat = 1'b1;
      res = fin_sign ? MIN_V : MAX_V;
    end else if (fin_sign) begin
      if (fin_mag > NEG_LIM) begin
        sat = 1'b1;
        res = MIN_V;
      end else begin
        res = -fin_mag[OUT_W-1:0];
      end
    end else if (fin_mag > POS_LIM) begin
      sat = 1'b1;
      res = MAX_V;
    end else begin
      res = fin_mag[OUT_W-1:0];
    end
  end

  logic unused_sign;
  assign unused_sign = sig_sign;

endmodule

// File: rtl/float2int_pipe.sv
// Three-stage float -> signed int converter with valid/ready and a global stall.
module float2int_pipe import fp_pkg::*; #(
  parameter int MAN   = fp_pkg::MAN,
  parameter int EXP   = fp_pkg::EXP,
  parameter int OUT_W = fp_pkg::OUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN+EXP:0]     in_float,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_int,
  output logic                 out_sat,
  output logic                 out_nan
);

  localparam int STAGES = 3;
  localparam int BIAS_L = (1 << (EXP - 1)) - 1;
  localparam logic signed [EXP:0] BIAS_E = (EXP+1)'(BIAS_L);

  logic [STAGES:1] vld_pipe;
  logic            en;

  // S1 / S2 registers
  logic                s1_sign;
  logic signed [EXP:0] s1_e;
  logic [MAN:0]        s1_sig;
  fcls_e               s1_cls;
  logic                s2_sign;
  logic [OUT_W:0]      s2_mag;
  logic                s2_ovf;
  logic                s2_nan;

  // decode and core outputs
  logic                f_sign;
  logic [EXP-1:0]      f_exp;
  logic [MAN-1:0]      f_frac;
  logic signed [EXP:0] d_e;
  fcls_e               d_cls;
  logic [OUT_W:0]      c_mag;
  logic                c_ovf, c_nan;
  logic [OUT_W-1:0]    c_res;
  logic                c_sat, c_res_nan;

  // A full output stage only blocks when the sink is not taking it.
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  assign f_sign = in_float[MAN+EXP];
  assign f_exp  = in_float[MAN+EXP-1:MAN];
  assign f_frac = in_float[MAN-1:0];
  assign d_e    = $signed({1'b0, f_exp}) - BIAS_E;

  // Classify the incoming word; denormals fold into ZERO.
  always_comb begin
    d_cls = NORM;
    if (f_exp == '0)       d_cls = ZERO;
    else if (&f_exp)       d_cls = (f_frac == '0) ? INF : NAN;
  end

  // Valid chain: shifts only when the whole pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1 decode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign <= 1'b0;
      s1_e    <= '0;
      s1_sig  <= '0;
      s1_cls  <= ZERO;
    end else if (en) begin
      s1_sign <= f_sign;
      s1_e    <= d_e;
      s1_sig  <= {1'b1, f_frac};
      s1_cls  <= d_cls;
    end
  end

  float2int_core #(.MAN(MAN), .EXP(EXP), .OUT_W(OUT_W)) u_core (
    .sig_sign (s1_sign),
    .sig      (s1_sig),
    .e        (s1_e),
    .cls      (s1_cls),
    .mag      (c_mag),
    .ovf      (c_ovf),
    .nan      (c_nan),
    .fin_sign (s2_sign),
    .fin_mag  (s2_mag),
    .fin_ovf  (s2_ovf),
    .fin_nan  (s2_nan),
    .res      (c_res),
    .sat      (c_sat),
    .res_nan  (c_res_nan)
  );

  // S2 shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sign <= 1'b0;
      s2_mag  <= '0;
      s2_ovf  <= 1'b0;
      s2_nan  <= 1'b0;
    end else if (en) begin
      s2_sign <= s1_sign;
      s2_mag  <= c_mag;
      s2_ovf  <= c_ovf;
      s2_nan  <= c_nan;
    end
  end

  // S3 output registers; held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_int <= '0;
      out_sat <= 1'b0;
      out_nan <= 1'b0;
    end else if (en) begin
      out_int <= c_res;
      out_sat <= c_sat;
      out_nan <= c_res_nan;
    end
  end

endmodule

// File: tb/tb_float2int_pipe.sv
// Directed bench for float2int_pipe: values, edges, specials, stalls, bubbles, reset.
module tb_float2int_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_float = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] out_int;
  logic        out_sat;
  logic        out_nan;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] f;
    int          v;
    logic        sat;
    logic        nan;
  } vec_t;

  // Hand-computed expectations for OUT_W = 23 (range -4194304 .. 4194303).
  vec_t tbl [12] = '{
    '{32'h3F800000,        1, 1'b0, 1'b0},
    '{32'hC0200000,       -2, 1'b0, 1'b0},
    '{32'h3F400000,        0, 1'b0, 1'b0},
    '{32'h4A7FFFFE,  4194303, 1'b0, 1'b0},
    '{32'h4A800000,  4194303, 1'b1, 1'b0},
    '{32'hCA800000, -4194304, 1'b0, 1'b0},
    '{32'hCB000000, -4194304, 1'b1, 1'b0},
    '{32'h7F800000,  4194303, 1'b1, 1'b0},
    '{32'hFF800000, -4194304, 1'b1, 1'b0},
    '{32'h7FC00000,        0, 1'b0, 1'b1},
    '{32'h80000000,        0, 1'b0, 1'b0},
    '{32'h00000001,        0, 1'b0, 1'b0}
  };

  always #5 clk = ~clk;

  float2int_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_sat   (out_sat),
    .out_nan   (out_nan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_int !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b int=%h, want valid=0 int=0", out_valid, out_int);
    end
    n_checks++;
    if (out_sat !== 1'b0 || out_nan !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got sat=%b nan=%b, want 0 0", out_sat, out_nan);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  // All 12 vectors back to back; each result must appear exactly 3 cycles later.
  task automatic test_values();
    int k;
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c < 12) begin
        in_valid = 1'b1;
        in_float = tbl[c].f;
      end else begin
        in_valid = 1'b0;
        in_float = '0;
      end
      step();
      if (c >= 2 && c < 14) begin
        k = c - 2;
        n_checks++;
        if (out_valid !== 1'b1 || out_int !== 23'(tbl[k].v) ||
            out_sat !== tbl[k].sat || out_nan !== tbl[k].nan) begin
          n_fail++;
          $display("FAIL value[%0d] in=%h: got valid=%b int=%0d sat=%b nan=%b, want valid=1 int=%0d sat=%b nan=%b",
                   k, tbl[k].f, out_valid, $signed(out_int), out_sat, out_nan,
                   tbl[k].v, tbl[k].sat, tbl[k].nan);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL value_latency cycle %0d: got valid=%b, want 0", c, out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rdy_pat;
    int          q[$];
    int          sent, got, cyc, idx;
    logic        stalled, h_sat, h_nan;
    logic [22:0] h_int;
    rdy_pat = 32'b1011_0010_1110_0101_1001_1100_0110_0011;
    sent = 0; got = 0; cyc = 0;
    h_int = '0; h_sat = 1'b0; h_nan = 1'b0;
    while (got < 10 && cyc < 200) begin
      out_ready = rdy_pat[cyc % 32];
      in_valid  = (sent < 10);
      in_float  = (sent < 10) ? tbl[sent].f : 32'h0;
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL bp_in_ready cycle %0d: got %b, want %b", cyc, in_ready, (!out_valid || out_ready));
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        h_int = out_int; h_sat = out_sat; h_nan = out_nan;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_output cycle %0d: got int=%0d, want no output", cyc, $signed(out_int));
        end else begin
          idx = q.pop_front();
          if (out_int !== 23'(tbl[idx].v) || out_sat !== tbl[idx].sat || out_nan !== tbl[idx].nan) begin
            n_fail++;
            $display("FAIL bp_value[%0d]: got int=%0d sat=%b nan=%b, want int=%0d sat=%b nan=%b",
                     idx, $signed(out_int), out_sat, out_nan, tbl[idx].v, tbl[idx].sat, tbl[idx].nan);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(sent);
        sent++;
      end
      step();
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_int !== h_int || out_sat !== h_sat || out_nan !== h_nan) begin
          n_fail++;
          $display("FAIL bp_hold cycle %0d: got valid=%b int=%h sat=%b nan=%b, want valid=1 int=%h sat=%b nan=%b",
                   cyc, out_valid, out_int, out_sat, out_nan, h_int, h_sat, h_nan);
        end
      end
      cyc++;
    end
    n_checks++;
    if (got != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, want 10", got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic [4:0] pat;
    logic       want;
    pat = 5'b01101;  // cycle order 1,0,1,1,0
    out_ready = 1'b1;
    in_float  = tbl[0].f;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5) ? pat[c] : 1'b0;
      step();
      want = (c >= 2 && c < 7) ? pat[c-2] : 1'b0;
      n_checks++;
      if (out_valid !== want || (want && out_int !== 23'd1)) begin
        n_fail++;
        $display("FAIL bubble cycle %0d: got valid=%b int=%0d, want valid=%b int=1", c, out_valid, $signed(out_int), want);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_float = tbl[c+6].f;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got valid=%b sat=%b, want 1 1", out_valid, out_sat);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_int !== 23'd0 || out_sat !== 1'b0 || out_nan !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid=%b int=%h sat=%b nan=%b, want 0 0 0 0", out_valid, out_int, out_sat, out_nan);
    end
    step();
    step();
    #2;
    rst = 1'b0;
    in_valid = 1'b1;
    in_float = 32'h40400000;  // 3.0
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale1: got valid=%b, want 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale2: got valid=%b, want 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_int !== 23'd3 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_first: got valid=%b int=%0d sat=%b, want valid=1 int=3 sat=0", out_valid, $signed(out_int), out_sat);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float2int_pipe.md
Name: float2int_pipe

Overview:
- Pipelined single-precision float to signed-integer converter; the inverse direction of the existing int-to-float front end.
- Converts IIR float outputs (y_float) back to a signed integer sample of the same width as the filter input x, for DAC/logging paths.
- Truncates toward zero, saturates out-of-range values and flags NaN.
- Uses a valid/ready stream handshake with full backpressure, at one sample per cycle.

Parameters:
- MAN, 23, mantissa field width; the float word is MAN+EXP+1 bits.
- EXP, 8, exponent field width; bias = 2^(EXP-1)-1 = 127.
- OUT_W, 23, signed integer output width; matches the filter input width MAN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_float holds a sample.
- in_ready  out  1  converter accepts a sample this cycle.
- in_float  in  MAN+EXP+1  float word: [MAN+EXP] sign, [MAN+EXP-1:MAN] exponent, [MAN-1:0] fraction.
- out_valid  out  1  out_int and its flags are valid.
- out_ready  in  1  sink accepts the output this cycle.
- out_int  out  OUT_W  signed two's-complement result.
- out_sat  out  1  result was clamped (overflow or ±inf).
- out_nan  out  1  input was NaN; out_int = 0.

Behaviour:
- Single clock. rst is asynchronous and active-high.
- On reset: all stage valids = 0, out_valid = 0, out_int = 0, out_sat = 0, out_nan = 0. in_ready = 1 one cycle after reset is released.
- Pipeline: 3 stages, each with its own valid bit.
  - S1 (decode): capture sign; compute e = exp - bias; compute significand = {1, fraction}; classify as zero/denorm, inf, NaN or normal.
  - S2 (shift): magnitude = significand shifted by (e - MAN); the right shift drops fraction bits, giving truncation toward zero.
  - S3 (finish): negate if sign = 1; saturate; register the outputs.
- Global stall enable: en = !v3 || out_ready. All stages advance only when en = 1. in_ready = en, combinational.
- Transfers: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 sample per cycle.
- While out_valid = 1 and out_ready = 0: out_int and all flags are held stable, and no stage changes.
- Bubbles (in_valid = 0 while en = 1) propagate as valid = 0 and do not stall upstream data.
- Classification and results:
  - exp == 0 (zero/denormal): result 0, no flags; denormals are flushed.
  - e < 0 (|x| < 1): result 0, no flag.
  - Positive with magnitude > 2^(OUT_W-1)-1: result 2^(OUT_W-1)-1, out_sat = 1.
  - Negative with magnitude > 2^(OUT_W-1): result -2^(OUT_W-1), out_sat = 1. A magnitude of exactly 2^(OUT_W-1) with sign = 1 is exact, with no sat.
  - exp all ones and fraction == 0 (±inf): saturate per sign, out_sat = 1.
  - exp all ones and fraction != 0 (NaN): result 0, out_nan = 1, out_sat = 0.
- The shift must never be evaluated for e ≥ OUT_W+1; overflow is detected from e before shifting. The S2 magnitude register is OUT_W+1 bits.
- -0.0 gives 0.
- rst asserted mid-stream: all in-flight samples are discarded immediately and outputs return to reset values. No partial output is emitted after reset is released.

Decomposition:
- Shared package fp_pkg holds:
  - field-extraction constants MAN, EXP and BIAS;
  - class encoding (ZERO, NORM, INF, NAN) as a 2-bit typedef;
  - OUT_MAX and OUT_MIN constants derived from OUT_W.
- The stall-enable/valid chain stays inline.
- One natural sub-module: float2int_core, the combinational S2 shift plus S3 saturate datapath. It has no state, and the pipe registers around it.

Test Plan:
- Basic values, out_ready = 1, one sample per cycle:
  - 0x3F800000 → 1
  - 0xC0200000 (-2.5) → -2
  - 0x3F400000 (0.75) → 0
  - Each appears exactly 3 cycles after acceptance, in order.
- Range edges:
  - 0x4A7FFFFE → 4194303, sat = 0
  - 0x4A800000 (2^22) → 4194303, sat = 1
  - 0xCA800000 → -4194304, sat = 0
  - 0xCB000000 → -4194304, sat = 1
- Specials:
  - 0x7F800000 → 4194303, sat = 1
  - 0xFF800000 → -4194304, sat = 1
  - 0x7FC00000 → 0, nan = 1
  - 0x80000000 → 0
  - 0x00000001 → 0
- Backpressure: stream 10 samples while toggling out_ready with a random pattern.
  - in_ready tracks the enable rule.
  - Outputs are held while stalled.
  - Output sequence equals the input sequence with no loss or duplication.
- Bubbles: in_valid pattern 1,0,1,1,0 with out_ready = 1 → out_valid pattern identical, delayed 3 cycles.
- Reset mid-stream: assert rst with 3 samples in flight.
  - out_valid = 0 immediately, not at the next clock edge.
  - After release, the next accepted sample is the first output.
